// File: rtl/txs_burst_arb.sv
// Round-robin burst arbiter driving an Avalon-MM burst write master for NREQ requesters.
// Define TXS_BURST_ARB_STATS_EN to enable the per-requester accepted-beat counters on beat_cnt.
module txs_burst_arb #(
  parameter int NREQ = 3,
  parameter int BMAX = 32
) (
  input  logic                 clk125,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req,
  input  logic [22*NREQ-1:0]   req_addr,
  input  logic [6*NREQ-1:0]    req_len,
  input  logic [128*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]      beat_rd,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      len_err,
  output logic                 txs_write,
  output logic [127:0]         txs_writedata,
  output logic [21:0]          txs_address,
  output logic [5:0]           txs_burstcount,
  input  logic                 txs_waitrequest,
  output logic                 busy,
  output logic [32*NREQ-1:0]   beat_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [NREQ-1:0] r_len_err, w_len_err_nxt;
  logic            r_write, w_write_nxt;
  logic [21:0]     r_addr, w_addr_nxt;
  logic [5:0]      r_bcnt, w_bcnt_nxt;
  logic [5:0]      r_left, w_left_nxt;
  logic [IW-1:0]   r_cur, w_cur_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;

  logic            w_sel_vld;
  logic [IW-1:0]   w_sel;
  logic [NREQ-1:0] w_sel_oh;
  logic [5:0]      w_sel_len;
  logic [21:0]     w_sel_addr;
  logic            w_len_ok;
  logic            w_accept;
  logic [127:0]    w_wdata;

  // Round-robin search: offsets 1..NREQ from the last owner, first pending request wins.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel      = '0;
    w_sel_oh   = '0;
    w_sel_len  = '0;
    w_sel_addr = '0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_sel_vld && req[j] && (j == (int'(r_last) + i) % NREQ)) begin
          w_sel_vld = 1'b1;
          w_sel     = IW'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (w_sel_vld && (w_sel == IW'(j))) begin
        w_sel_oh[j] = 1'b1;
        w_sel_len   = req_len[6*j +: 6];
        w_sel_addr  = req_addr[22*j +: 22];
      end
    end
  end

  assign w_len_ok = (w_sel_len != 6'd0) && ({26'd0, w_sel_len} <= 32'(BMAX));
  assign w_accept = r_write && !txs_waitrequest;

  always_comb begin
    w_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (r_cur == IW'(j)) w_wdata = req_data[128*j +: 128];
    end
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_len_err <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_bcnt    <= '0;
      r_left    <= '0;
      r_cur     <= '0;
      r_last    <= IW'(NREQ - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_len_err <= w_len_err_nxt;
      r_write   <= w_write_nxt;
      r_addr    <= w_addr_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_left    <= w_left_nxt;
      r_cur     <= w_cur_nxt;
      r_last    <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_len_err_nxt = '0;
    w_write_nxt   = r_write;
    w_addr_nxt    = r_addr;
    w_bcnt_nxt    = r_bcnt;
    w_left_nxt    = r_left;
    w_cur_nxt     = r_cur;
    w_last_nxt    = r_last;
    case (r_state)
      S_IDLE: begin
        if (enable && w_sel_vld) begin
          if (w_len_ok) begin
            w_state_nxt = S_BURST;
            w_grant_nxt = w_sel_oh;
            w_write_nxt = 1'b1;
            w_addr_nxt  = w_sel_addr;
            w_bcnt_nxt  = w_sel_len;
            w_left_nxt  = w_sel_len;
            w_cur_nxt   = w_sel;
          end else begin
            // Refused requester is skipped so the others are not starved by it.
            w_len_err_nxt = w_sel_oh;
            w_last_nxt    = w_sel;
          end
        end
      end
      S_BURST: begin
        if (w_accept) begin
          w_left_nxt = r_left - 6'd1;
          if (r_left == 6'd1) begin
            w_state_nxt = S_IDLE;
            w_write_nxt = 1'b0;
            w_grant_nxt = '0;
            w_last_nxt  = r_cur;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pop and done strobes are qualified by waitrequest in the accepting cycle itself.
  assign beat_rd        = w_accept ? r_grant : '0;
  assign done           = (w_accept && (r_left == 6'd1)) ? r_grant : '0;
  assign grant          = r_grant;
  assign len_err        = r_len_err;
  assign txs_write      = r_write;
  assign txs_writedata  = w_wdata;
  assign txs_address    = r_addr;
  assign txs_burstcount = r_bcnt;
  assign busy           = (r_state == S_BURST);

`ifdef TXS_BURST_ARB_STATS_EN
  logic [31:0] r_beat_cnt [NREQ];

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) r_beat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (beat_rd[i]) r_beat_cnt[i] <= r_beat_cnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < NREQ; i++) beat_cnt[32*i +: 32] = r_beat_cnt[i];
  end
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_txs_burst_arb.sv
// Bench for txs_burst_arb: directed scenarios plus random traffic against a burst-level model.
module tb_txs_burst_arb;
  localparam int NREQ = 3;
  localparam int BMAX = 32;

  logic                 clk125 = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic [NREQ-1:0]      req;
  logic [22*NREQ-1:0]   req_addr;
  logic [6*NREQ-1:0]    req_len;
  logic [128*NREQ-1:0]  req_data;
  logic [NREQ-1:0]      beat_rd, grant, done, len_err;
  logic                 txs_write;
  logic [127:0]         txs_writedata;
  logic [21:0]          txs_address;
  logic [5:0]           txs_burstcount;
  logic                 txs_waitrequest;
  logic                 busy;
  logic [32*NREQ-1:0]   beat_cnt;

  txs_burst_arb #(.NREQ(NREQ), .BMAX(BMAX)) dut (
    .clk125(clk125), .rst_n(rst_n), .enable(enable), .req(req),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .beat_rd(beat_rd), .grant(grant), .done(done), .len_err(len_err),
    .txs_write(txs_write), .txs_writedata(txs_writedata),
    .txs_address(txs_address), .txs_burstcount(txs_burstcount),
    .txs_waitrequest(txs_waitrequest), .busy(busy), .beat_cnt(beat_cnt)
  );

  always #4 clk125 = ~clk125;

  int n_cmp = 0;
  int n_err = 0;

  // Observations of the DUT gathered by the checker, used by the literal checks.
  int obs_beats [NREQ];
  int obs_done  [NREQ];
  int obs_le    [NREQ];
  int obs_wcyc  = 0;
  int g_log[$];
  int gap_log[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: burst-level view of the arbiter, stepped once per cycle.
  initial begin
    bit              m_busy;
    int              m_own, m_left, m_last, idle_run;
    logic [21:0]     m_addr;
    logic [5:0]      m_cnt;
    logic [NREQ-1:0] m_le, e_oh, e_rd, e_done;
    logic [31:0]     m_bc [NREQ];
    bit              acc, prev_w;
    m_busy = 0; m_own = 0; m_left = 0; m_last = NREQ-1; m_addr = 0; m_cnt = 0; m_le = 0;
    prev_w = 0; idle_run = 0;
    for (int r = 0; r < NREQ; r++) begin
      m_bc[r] = 0; obs_beats[r] = 0; obs_done[r] = 0; obs_le[r] = 0;
    end
    forever begin
      @(negedge clk125);
      if (!rst_n) begin
        m_busy = 0; m_own = 0; m_left = 0; m_last = NREQ-1; m_addr = 0; m_cnt = 0; m_le = 0;
        for (int r = 0; r < NREQ; r++) m_bc[r] = 0;
        chk("rst_write", txs_write, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_beat_rd", beat_rd, 0);
        chk("rst_done", done, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_addr", txs_address, 0);
        chk("rst_bcnt", txs_burstcount, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        prev_w = 0;
        continue;
      end
      e_oh   = m_busy ? (NREQ'(1) << m_own) : '0;
      acc    = m_busy && !txs_waitrequest;
      e_rd   = acc ? e_oh : '0;
      e_done = (acc && m_left == 1) ? e_oh : '0;
      chk("write", txs_write, m_busy);
      chk("busy", busy, m_busy);
      chk("grant", grant, e_oh);
      chk("address", txs_address, m_addr);
      chk("burstcount", txs_burstcount, m_cnt);
      chk("beat_rd", beat_rd, e_rd);
      chk("done", done, e_done);
      chk("len_err", len_err, m_le);
      if (m_busy) chk("writedata", txs_writedata, req_data[128*m_own +: 128]);
`ifdef TXS_BURST_ARB_STATS_EN
      for (int r = 0; r < NREQ; r++) chk("beat_cnt", beat_cnt[32*r +: 32], m_bc[r]);
`else
      chk("beat_cnt_tied", beat_cnt, 0);
`endif
      // Observation log
      if (txs_write && !prev_w) begin
        int o;
        o = -1;
        for (int r = 0; r < NREQ; r++) if (grant[r]) o = r;
        g_log.push_back(o);
        gap_log.push_back(idle_run);
      end
      idle_run = txs_write ? 0 : idle_run + 1;
      prev_w = txs_write;
      if (txs_write) obs_wcyc++;
      for (int r = 0; r < NREQ; r++) begin
        obs_beats[r] += int'(beat_rd[r]);
        obs_done[r]  += int'(done[r]);
        obs_le[r]    += int'(len_err[r]);
      end
      // Advance the model to the next cycle
      m_le = '0;
      if (m_busy) begin
        if (acc) begin
          m_bc[m_own] = m_bc[m_own] + 1;
          m_left--;
          if (m_left == 0) begin
            m_busy = 0;
            m_last = m_own;
          end
        end
      end else if (enable && (req != 0)) begin
        int s, l;
        s = 0;
        for (int k = 1; k <= NREQ; k++) begin
          s = (m_last + k) % NREQ;
          if (req[s]) break;
        end
        l = int'(req_len[6*s +: 6]);
        if (l == 0 || l > BMAX) begin
          m_le[s] = 1'b1;
          m_last = s;
        end else begin
          m_busy = 1; m_own = s; m_left = l;
          m_addr = req_addr[22*s +: 22];
          m_cnt  = req_len[6*s +: 6];
        end
      end
    end
  end

  // Show-ahead source: each requester presents a new random word after every pop.
  initial begin
    logic [NREQ-1:0] br;
    for (int r = 0; r < NREQ; r++) req_data[128*r +: 128] = {$urandom, $urandom, $urandom, $urandom};
    forever begin
      @(negedge clk125);
      br = beat_rd;
      @(posedge clk125);
      #1;
      for (int r = 0; r < NREQ; r++)
        if (br[r] === 1'b1) req_data[128*r +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic cyc();
    @(posedge clk125);
    #1;
  endtask

  task automatic set_req(int r, bit v, logic [21:0] a, logic [5:0] l);
    req[r] = v;
    req_addr[22*r +: 22] = a;
    req_len[6*r +: 6] = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wait_done(int r, int budget);
    int k;
    k = 0;
    forever begin
      @(negedge clk125);
      if (done[r]) break;
      k++;
      if (k > budget) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    cyc();
  endtask

  task automatic wait_ndone(int n, int budget);
    int k, c;
    k = 0; c = 0;
    forever begin
      @(negedge clk125);
      c += $countones(done);
      if (c >= n) break;
      k++;
      if (k > budget) begin
        chk("ndone_timeout", 0, 1);
        break;
      end
    end
    cyc();
  endtask

  task automatic wait_beats(int r, int target, int budget);
    int k;
    k = 0;
    forever begin
      @(negedge clk125);
      if (obs_beats[r] >= target) break;
      k++;
      if (k > budget) begin
        chk("beats_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int sb, sd, sw, sg, sl;
    logic [NREQ-1:0] d, le;
    rst_n = 1'b0; enable = 1'b0; req = '0; req_addr = '0; req_len = '0; txs_waitrequest = 1'b0;
    cyc();
    do_reset();
    chk("reset_write", txs_write, 0);
    chk("reset_grant", grant, 0);
    enable = 1'b1;

    // Single 8-beat burst from requester 0
    sb = obs_beats[0]; sd = obs_done[0]; sw = obs_wcyc;
    set_req(0, 1, 22'h100, 6'd8);
    cyc();
    chk("lat1_write", txs_write, 1);
    chk("lat1_addr", txs_address, 22'h100);
    chk("lat1_bcnt", txs_burstcount, 6'd8);
    chk("lat1_grant", grant, 3'b001);
    wait_done(0, 40);
    set_req(0, 0, 22'h100, 6'd8);
    cyc();
    chk("b8_beats", obs_beats[0] - sb, 8);
    chk("b8_done", obs_done[0] - sd, 1);
    chk("b8_wcyc", obs_wcyc - sw, 8);

    // All three requesting with len=4
    do_reset();
    sg = g_log.size();
    set_req(0, 1, 22'h010, 6'd4);
    set_req(1, 1, 22'h020, 6'd4);
    set_req(2, 1, 22'h030, 6'd4);
    wait_ndone(4, 60);
    req = '0;
    cyc();
    chk("rr_count", (g_log.size() - sg) >= 4, 1);
    if (g_log.size() - sg >= 4) begin
      chk("rr_g0", g_log[sg], 0);
      chk("rr_g1", g_log[sg+1], 1);
      chk("rr_g2", g_log[sg+2], 2);
      chk("rr_g3", g_log[sg+3], 0);
      chk("rr_gap1", gap_log[sg+1], 1);
      chk("rr_gap2", gap_log[sg+2], 1);
      chk("rr_gap3", gap_log[sg+3], 1);
    end

    // Stall on beats 3..5
    sb = obs_beats[0]; sd = obs_done[0]; sw = obs_wcyc;
    set_req(0, 1, 22'h2A0, 6'd8);
    cyc();
    for (int c = 0; c < 11; c++) begin
      txs_waitrequest = (c >= 2 && c <= 4);
      cyc();
    end
    txs_waitrequest = 1'b0;
    set_req(0, 0, 22'h2A0, 6'd8);
    cyc();
    chk("stall_beats", obs_beats[0] - sb, 8);
    chk("stall_done", obs_done[0] - sd, 1);
    chk("stall_wcyc", obs_wcyc - sw, 11);

    // Illegal lengths 0 and 33 on requester 1
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      sl = obs_le[1]; sg = g_log.size(); sw = obs_wcyc;
      set_req(1, 1, 22'h011, (pass == 0) ? 6'd0 : 6'd33);
      set_req(2, 1, 22'h022, 6'd4);
      wait_done(2, 30);
      req = '0;
      cyc();
      chk("lenerr_pulse", obs_le[1] - sl, 1);
      chk("lenerr_ngrant", g_log.size() - sg, 1);
      if (g_log.size() > sg) chk("lenerr_next", g_log[sg], 2);
      chk("lenerr_wcyc", obs_wcyc - sw, 4);
    end

    // Enable dropped at beat 2 of 16
    sb = obs_beats[0]; sg = g_log.size();
    set_req(0, 1, 22'h300, 6'd16);
    wait_beats(0, sb + 2, 20);
    cyc();
    enable = 1'b0;
    wait_done(0, 40);
    set_req(0, 0, 22'h300, 6'd16);
    set_req(1, 1, 22'h040, 6'd4);
    repeat (10) cyc();
    chk("en_beats", obs_beats[0] - sb, 16);
    chk("en_nogrant", g_log.size() - sg, 1);
    chk("en_write_low", txs_write, 0);
    enable = 1'b1;
    wait_done(1, 20);
    set_req(1, 0, 22'h040, 6'd4);
    cyc();

    // Reset at beat 5 of 8
    sb = obs_beats[0];
    set_req(0, 1, 22'h500, 6'd8);
    wait_beats(0, sb + 4, 20);
    @(posedge clk125);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_write", txs_write, 0);
    chk("async_grant", grant, 0);
    chk("async_busy", busy, 0);
    req = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    sg = g_log.size();
    set_req(0, 1, 22'h600, 6'd4);
    set_req(1, 1, 22'h700, 6'd4);
    wait_ndone(1, 20);
    req = '0;
    cyc();
    chk("post_rst_ngrant", g_log.size() - sg, 1);
    if (g_log.size() > sg) chk("post_rst_first", g_log[sg], 0);
    cyc();

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk125);
      d = done;
      le = len_err;
      cyc();
      for (int r = 0; r < NREQ; r++) begin
        if (req[r] && (d[r] || le[r])) begin
          req[r] = 1'b0;
        end else if (!req[r] && $urandom_range(0, 3) == 0) begin
          logic [5:0] l;
          case ($urandom_range(0, 15))
            0:       l = 6'd0;
            1:       l = 6'($urandom_range(33, 63));
            2:       l = 6'($urandom_range(9, BMAX));
            default: l = 6'($urandom_range(1, 8));
          endcase
          set_req(r, 1, 22'($urandom), l);
        end else if (req[r] && grant[r] && $urandom_range(0, 49) == 0) begin
          req[r] = 1'b0;
        end
      end
      txs_waitrequest = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 15) != 0);
    end
    req = '0;
    enable = 1'b1;
    txs_waitrequest = 1'b0;
    repeat (80) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
